// File: rtl/cpu_arith_pkg.sv
// rtl/cpu_arith_pkg.sv - shared arithmetic types and helpers for the execute stage
package cpu_arith_pkg;

  // Default operand width of the execute-stage arithmetic units.
  localparam int ARITH_W = 32;

  // Widest operand abs_val handles; callers extend their operands to this width.
  localparam int ARITH_MAX_W = 64;

  typedef logic [ARITH_MAX_W-1:0] arith_wide_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } div_state_t;

  // Magnitude of a (sign-extended) operand; the most negative value maps to
  // its own bit pattern, which is the correct unsigned magnitude once truncated.
  function automatic arith_wide_t abs_val(input arith_wide_t value, input logic is_signed);
    return (is_signed && value[ARITH_MAX_W-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one combinational non-restoring division step
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_low,   // partial remainder without its sign bit
  input  logic             prev_neg,  // sign bit of the partial remainder
  input  logic             dvd_bit,   // next dividend bit shifted in
  input  logic [WIDTH-1:0] divisor,   // divisor magnitude
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;

  // Shift in the next dividend bit, then subtract when the remainder was
  // non-negative or add back when it was negative; the result always fits
  // WIDTH+1 bits even though the shifted intermediate may wrap.
  always_comb begin
    shifted  = {rem_low, dvd_bit};
    dvs_ext  = {1'b0, divisor};
    rem_next = prev_neg ? (shifted + dvs_ext) : (shifted - dvs_ext);
    q_bit    = ~rem_next[WIDTH];
  end

endmodule

// File: rtl/divider_unit.sv
// rtl/divider_unit.sv - iterative signed/unsigned divider; DIVIDER_DBZ_FAST_EN shortcuts zero divisors
module divider_unit
  import cpu_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] q_work;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dvs_mag;
  logic             q_neg;
  logic             r_neg;

  arith_wide_t      dvd_ext;
  arith_wide_t      dvs_ext;
  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag_in;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;

  // Operand magnitudes: sign-extend only in signed mode, then take abs_val.
  always_comb begin
    dvd_ext             = {ARITH_MAX_W{is_signed & dividend[WIDTH-1]}};
    dvd_ext[WIDTH-1:0]  = dividend;
    dvs_ext             = {ARITH_MAX_W{is_signed & divisor[WIDTH-1]}};
    dvs_ext[WIDTH-1:0]  = divisor;
    dvd_mag_in          = WIDTH'(abs_val(dvd_ext, is_signed));
    dvs_mag_in          = WIDTH'(abs_val(dvs_ext, is_signed));
  end

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_low  (rem[WIDTH-1:0]),
    .prev_neg (rem[WIDTH]),
    .dvd_bit  (q_work[WIDTH-1]),
    .divisor  (dvs_mag),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Final correction: restore a negative remainder, then apply operand signs.
  always_comb begin
    r_mag   = rem[WIDTH-1:0] + (rem[WIDTH] ? dvs_mag : '0);
    q_fixed = q_neg ? -q_work : q_work;
    r_fixed = r_neg ? -r_mag : r_mag;
`ifdef DIVIDER_DBZ_FAST_EN
    if (dvs_mag == '0) begin
      q_fixed = '1;
      r_fixed = q_work;
    end
`endif
  end

  // Control FSM: accept, iterate WIDTH steps, fix up and publish registered results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      rem     <= '0;
      q_work  <= '0;
      dvs_mag <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_work  <= dvd_mag_in;
            dvs_mag <= dvs_mag_in;
            q_neg   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg   <= is_signed & dividend[WIDTH-1];
            rem     <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef DIVIDER_DBZ_FAST_EN
            // Zero divisor: keep the raw dividend for r and skip the iteration.
            if (divisor == '0) begin
              q_work <= dividend;
              state  <= FIX;
            end
`endif
          end
        end
        RUN: begin
          rem    <= step_rem;
          q_work <= {q_work[WIDTH-2:0], step_q};
          if (count == CNT_W'(WIDTH - 1)) begin
            count <= '0;
            state <= FIX;
          end else begin
            count <= count + 1'b1;
          end
        end
        FIX: begin
          q     <= q_fixed;
          r     <= r_fixed;
          dbz   <= (dvs_mag == '0);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// tb/tb_divider_unit.sv - self-checking bench for divider_unit
module tb_divider_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        dbz;

  logic        start8;
  logic        sg8;
  logic [7:0]  dvd8;
  logic [7:0]  dvs8;
  logic [7:0]  q8;
  logic [7:0]  r8;
  logic        busy8;
  logic        done8;
  logic        dbz8;

  int checks   = 0;
  int failures = 0;

  divider_unit dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .q         (q),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz)
  );

  divider_unit #(.WIDTH(8)) dut8 (
    .clock     (clock),
    .reset     (reset),
    .start     (start8),
    .is_signed (sg8),
    .dividend  (dvd8),
    .divisor   (dvs8),
    .q         (q8),
    .r         (r8),
    .busy      (busy8),
    .done      (done8),
    .dbz       (dbz8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    bit          sg;
    logic [31:0] q;
    logic [31:0] r;
    bit          dz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; divide-by-zero follows the documented result rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sg,
                                output logic [31:0] qe, output logic [31:0] re, output bit dz);
    longint          sa, sb;
    longint unsigned ua, ub;
    dz = (b == 32'd0);
    if (b == 32'd0) begin
`ifdef DIVIDER_DBZ_FAST_EN
      qe = 32'hFFFF_FFFF;
      re = a;
`else
      // magnitude quotient is all-ones, negated when the dividend is negative;
      // remainder is |a| with the dividend's sign, i.e. a itself
      qe = (sg && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      re = a;
`endif
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qe = 32'(sa / sb);
      re = 32'(sa % sb);
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      qe = 32'(ua / ub);
      re = 32'(ua % ub);
    end
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
`ifdef DIVIDER_DBZ_FAST_EN
    if (b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Called at a negedge; start is seen by exactly one rising edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit sg);
    dividend  = a;
    divisor   = b;
    is_signed = sg;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Counts busy cycles (negedge samples before done); -1 on timeout.
  task automatic wait_done(output int busy_cyc);
    busy_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done) return;
      busy_cyc++;
    end
    busy_cyc = -1;
  endtask

  task automatic run_op(input string name, input int idx, input logic [31:0] a, input logic [31:0] b,
                        input bit sg, input logic [31:0] qe, input logic [31:0] re, input bit dz);
    int cyc;
    launch(a, b, sg);
    wait_done(cyc);
    check({name, "_lat"}, idx, 64'(cyc), 64'(exp_latency(b)));
    check({name, "_busy_at_done"}, idx, 64'(busy), 64'd0);
    check({name, "_q"}, idx, 64'(q), 64'(qe));
    check({name, "_r"}, idx, 64'(r), 64'(re));
    check({name, "_dbz"}, idx, 64'(dbz), 64'(dz));
  endtask

  initial begin
    logic [31:0] ra, rb, qe, re;
    bit          rs, dz, seen_done;
    int          cyc;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
    vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0};
    vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h10,        1'b0, 32'h0FFF_FFFF, 32'hF,         1'b0};
    vecs[5]  = '{32'hFFFF_FFFF, 32'h10,        1'b1, 32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{32'h1234,      32'd0,         1'b0, 32'hFFFF_FFFF, 32'h1234,      1'b1};
    vecs[7]  = '{32'hDEAD_BEEF, 32'd1,         1'b0, 32'hDEAD_BEEF, 32'd0,         1'b0};
    vecs[8]  = '{32'h0001_2345, 32'h0001_2345, 1'b0, 32'd1,         32'd0,         1'b0};
    vecs[9]  = '{32'd5,         32'd9,         1'b0, 32'd0,         32'd5,         1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1,         32'd0,         1'b0};
    vecs[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; sg8 = 1'b0; dvd8 = '0; dvs8 = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", 0, 64'(busy), 64'd0);
    check("rst_done", 0, 64'(done), 64'd0);
    check("rst_q",    0, 64'(q),    64'd0);
    check("rst_r",    0, 64'(r),    64'd0);
    check("rst_dbz",  0, 64'(dbz),  64'd0);
    reset = 1'b1;
    @(negedge clock);

    // directed table, issued back-to-back
    for (int i = 0; i < 12; i++)
      run_op("vec", i, vecs[i].dvd, vecs[i].dvs, vecs[i].sg, vecs[i].q, vecs[i].r, vecs[i].dz);

    // start mid-RUN is ignored; results hold during RUN
    launch(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clock);
    check("hold_q_in_run", 0, 64'(q), 64'd0);
    check("hold_r_in_run", 0, 64'(r), 64'h8000_0000);
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b1; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(cyc);
    check("ign_done_seen", 0, 64'(cyc >= 0), 64'd1);
    check("ign_q", 0, 64'(q), 64'd14);
    check("ign_r", 0, 64'(r), 64'd2);

    // start in the done cycle is accepted back-to-back
    check("b2b_done_now", 0, 64'(done), 64'd1);
    run_op("b2b", 0, 32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0);

    // asynchronous reset mid-RUN
    launch(32'd1000, 32'd7, 1'b0);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 0, 64'(busy), 64'd0);
    check("arst_done", 0, 64'(done), 64'd0);
    check("arst_q",    0, 64'(q),    64'd0);
    check("arst_r",    0, 64'(r),    64'd0);
    check("arst_dbz",  0, 64'(dbz),  64'd0);
    @(negedge clock);
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) seen_done = 1'b1;
    end
    check("no_done_after_rst", 0, 64'(seen_done), 64'd0);

    // WIDTH=8 instance
    dvd8 = 8'd200; dvs8 = 8'd13; sg8 = 1'b0; start8 = 1'b1;
    @(posedge clock);
    #1 start8 = 1'b0;
    cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done8) begin
        cyc = i;
        break;
      end
    end
    check("w8_lat", 0, 64'(cyc), 64'd9);
    check("w8_q", 0, 64'(q8), 64'd15);
    check("w8_r", 0, 64'(r8), 64'd5);

    // randomized against the reference model
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 300);
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2, 3: rb = $urandom_range(1, 20);
        4:       rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, qe, re, dz);
      run_op("rnd", i, ra, rb, rs, qe, re, dz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
Name: divider_unit

Overview:
- Parameterised iterative non-restoring divider, successor to the fixed 32-bit unsigned divider in the CPU execute stage.
- Adds a configurable operand width, a per-operation signed/unsigned mode, a one-cycle completion pulse, registered results and divide-by-zero reporting.
- Serves DIV/DIVU; the pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/quotient/remainder width; legal values are even and at least 4
CNT_W, $clog2(WIDTH), iteration counter width (derived; do not override)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (0 = reset asserted)
start  input  1  request; accepted only when busy=0
is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start
dividend  input  WIDTH  sampled on accepted start
divisor  input  WIDTH  sampled on accepted start
q  output  WIDTH  quotient, registered
r  output  WIDTH  remainder, registered
busy  output  1  operation in progress
done  output  1  one-cycle pulse when q/r are updated
dbz  output  1  divisor was zero for the last completed operation

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, done=0, dbz=0, q=0, r=0, counter=0. Reset mid-operation aborts with no done pulse.
- FSM states:
  - IDLE: an accepted start latches operands, mode and sign flags.
    - Signed operands are converted to magnitudes: a negative value is negated, and INT_MIN stays 100..0 as an unsigned magnitude.
    - Partial remainder is set to 0; go to RUN; busy=1.
  - RUN: one non-restoring step per clock, WIDTH steps, counter 0..WIDTH-1.
    - The partial remainder is WIDTH+1 bits.
    - If the previous remainder is non-negative: shift left and subtract the divisor magnitude. If negative: shift left and add it.
    - The quotient bit is the inverted sign of the result.
    - When the counter reaches WIDTH-1, go to FIX.
  - FIX (1 cycle):
    - If the remainder is negative, restore it by adding the divisor magnitude.
    - Signed mode: negate the quotient if the operand signs differed; the remainder takes the dividend's sign.
    - Write q/r and dbz, then go to IDLE, busy=0, done=1.
- Latency: start accepted at edge E0, then busy=1 for WIDTH+1 cycles, with done=1 and busy=0 after edge E0+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- Handshake:
  - start while busy=1 is ignored: operands are not sampled and no error is raised.
  - start in the cycle done=1 is accepted, since busy=0 then.
- q/r/dbz hold their values from done until the next FIX write; they do not change during RUN.
- Boundary values:
  - Signed INT_MIN / -1 gives q=INT_MIN, r=0, with no overflow flag.
  - Unsigned x/1 gives q=x, r=0.
  - x/x gives q=1, r=0.
  - Dividend smaller than divisor (unsigned) gives q=0, r=dividend.
- Divide-by-zero without the optional feature:
  - The full iteration runs; the unsigned core yields q=all-ones, r=|dividend|, and the sign fixup above applies.
  - dbz=1 for that result.

Optional Feature:
- Macro DIVIDER_DBZ_FAST_EN.
- Defined:
  - A zero divisor at accepted start skips RUN and goes IDLE -> FIX with a fixed result: q = all-ones, r = dividend (raw, no fixup), dbz=1.
  - busy=1 for exactly 1 cycle, with done after edge E0+1.
- Undefined:
  - A zero divisor takes the full WIDTH+1 cycles, with results as in Behaviour.
- Non-zero divisors are identical in both builds.

Decomposition:
- Shared package cpu_arith_pkg holds:
  - the state enum (IDLE, RUN, FIX);
  - the default operand width constant ARITH_W=32;
  - a function abs_val(value, is_signed).
- One natural sub-module: divider_step, the combinational WIDTH+1-bit add/subtract step taking remainder, next dividend bit, divisor and previous sign, and returning the new remainder and quotient bit.
- The FSM, counter and fixup stay in divider_unit.

Test Plan:
- Unsigned, WIDTH=32: 100 / 7 -> q=14, r=2; done after 33 busy cycles; busy falls in the done cycle.
- Signed: -7 / 2 -> q=-3 (0xFFFFFFFD), r=-1; 7 / -2 -> q=-3, r=1; INT_MIN / -1 -> q=0x80000000, r=0.
- Unsigned 0xFFFFFFFF / 0x10 -> q=0x0FFFFFFF, r=0xF.
  - Signed same bits gives -1/16 -> q=0, r=-1.
- Divisor 0, dividend 0x1234:
  - without the macro: q=0xFFFFFFFF, r=0x1234, dbz=1 after 33 busy cycles;
  - with the macro: same values after 1 busy cycle.
- start pulsed mid-RUN with new operands -> ignored, first result unaffected; start in the done cycle -> second operation accepted back-to-back.
- reset=0 asserted mid-RUN -> busy/done/q/r/dbz are 0 immediately (asynchronously); after release, no done pulse until a new start; WIDTH=8 regression 200/13 -> q=15, r=5.
